// File: rtl/bp_core_coh_mux.sv
// Concentrates N LCE coherence links onto one LCE-CCE link set.
// Optional grant counters: define BP_COH_MUX_STATS_EN.
module bp_core_coh_mux #(
  parameter int num_lce_p      = 2,
  parameter int lce_id_width_p = 4,
  parameter int req_width_p    = 64,
  parameter int resp_width_p   = 64,
  parameter int cmd_width_p    = 64,
  parameter int cmd_dst_lsb_p  = 0,
  parameter int credits_p      = 8
) (
  input  logic                                  clk_i,
  input  logic                                  reset_i,
  input  logic [num_lce_p*lce_id_width_p-1:0]   lce_id_i,
  input  logic [num_lce_p*req_width_p-1:0]      lce_req_i,
  input  logic [num_lce_p-1:0]                  lce_req_v_i,
  output logic [num_lce_p-1:0]                  lce_req_ready_o,
  output logic [req_width_p-1:0]                lce_req_o,
  output logic                                  lce_req_v_o,
  input  logic                                  lce_req_ready_i,
  input  logic [num_lce_p*resp_width_p-1:0]     lce_resp_i,
  input  logic [num_lce_p-1:0]                  lce_resp_v_i,
  output logic [num_lce_p-1:0]                  lce_resp_ready_o,
  output logic [resp_width_p-1:0]               lce_resp_o,
  output logic                                  lce_resp_v_o,
  input  logic                                  lce_resp_ready_i,
  input  logic [cmd_width_p-1:0]                lce_cmd_i,
  input  logic                                  lce_cmd_v_i,
  output logic                                  lce_cmd_yumi_o,
  output logic [num_lce_p*cmd_width_p-1:0]      lce_cmd_o,
  output logic [num_lce_p-1:0]                  lce_cmd_v_o,
  input  logic [num_lce_p-1:0]                  lce_cmd_yumi_i,
  input  logic [num_lce_p-1:0]                  credit_return_i,
  output logic [num_lce_p-1:0]                  credits_full_o,
  output logic [num_lce_p-1:0]                  credits_empty_o,
  output logic                                  error_o,
  output logic [num_lce_p*32-1:0]               stat_grants_o
);

  localparam int N   = num_lce_p;
  localparam int IW  = lce_id_width_p;
  localparam int RQW = req_width_p;
  localparam int RSW = resp_width_p;
  localparam int CMW = cmd_width_p;
  localparam int PW  = (N > 1) ? $clog2(N) : 1;
  localparam int CRW = $clog2(credits_p + 1);
  localparam logic [CRW-1:0] CMAX = CRW'(credits_p);

  // First requester at or after the pointer, wrapping around.
  function automatic logic [N-1:0] rr_pick(
    input logic [N-1:0]  v,
    input logic [PW-1:0] p
  );
    logic [N-1:0] g;
    logic         found;
    g     = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < N; k++) begin
        if (!found && v[k] && ((int'(p) + i) % N == k)) begin
          g[k]  = 1'b1;
          found = 1'b1;
        end
      end
    end
    return g;
  endfunction

  function automatic logic [PW-1:0] next_ptr(
    input logic [N-1:0]  g,
    input logic [PW-1:0] p
  );
    logic [PW-1:0] n;
    n = p;
    for (int k = 0; k < N; k++) begin
      if (g[k]) n = PW'((k + 1) % N);
    end
    return n;
  endfunction

  logic [CRW-1:0] cred_q [N];
  logic [CRW-1:0] cred_d [N];
  logic           uflow;

  logic           req_full_q, req_full_d;
  logic [RQW-1:0] req_data_q, req_data_d;
  logic [PW-1:0]  req_ptr_q, req_ptr_d;
  logic [N-1:0]   req_elig;
  logic           req_load;

  logic           resp_full_q, resp_full_d;
  logic [RSW-1:0] resp_data_q, resp_data_d;
  logic [PW-1:0]  resp_ptr_q, resp_ptr_d;
  logic           resp_load;

  logic [N-1:0]     cmd_full_q, cmd_full_d;
  logic [N*CMW-1:0] cmd_data_q, cmd_data_d;
  logic [IW-1:0]    cmd_dst;
  logic [N-1:0]     cmd_tgt;
  logic             cmd_hit;
  logic             cmd_miss;

  logic error_q, error_d;

  always_comb begin
    for (int k = 0; k < N; k++) begin
      credits_full_o[k]  = (cred_q[k] == CMAX);
      credits_empty_o[k] = (cred_q[k] == '0);
    end
  end

  always_comb begin
    for (int k = 0; k < N; k++) begin
      req_elig[k] = lce_req_v_i[k] & (cred_q[k] < CMAX);
    end
    req_load        = ~reset_i & (~req_full_q | lce_req_ready_i);
    lce_req_ready_o = rr_pick(req_elig, req_ptr_q)
                    & {N{req_load}} & ~credits_full_o;
    req_full_d      = req_full_q & ~lce_req_ready_i;
    req_data_d      = req_data_q;
    req_ptr_d       = req_ptr_q;
    if (|lce_req_ready_o) begin
      req_full_d = 1'b1;
      req_ptr_d  = next_ptr(lce_req_ready_o, req_ptr_q);
      for (int k = 0; k < N; k++) begin
        if (lce_req_ready_o[k]) req_data_d = lce_req_i[k*RQW +: RQW];
      end
    end
  end

  always_comb begin
    resp_load        = ~reset_i & (~resp_full_q | lce_resp_ready_i);
    lce_resp_ready_o = rr_pick(lce_resp_v_i, resp_ptr_q)
                     & {N{resp_load}};
    resp_full_d      = resp_full_q & ~lce_resp_ready_i;
    resp_data_d      = resp_data_q;
    resp_ptr_d       = resp_ptr_q;
    if (|lce_resp_ready_o) begin
      resp_full_d = 1'b1;
      resp_ptr_d  = next_ptr(lce_resp_ready_o, resp_ptr_q);
      for (int k = 0; k < N; k++) begin
        if (lce_resp_ready_o[k]) resp_data_d = lce_resp_i[k*RSW +: RSW];
      end
    end
  end

  // Simultaneous accept and return cancel out.
  always_comb begin
    uflow = 1'b0;
    for (int k = 0; k < N; k++) begin
      cred_d[k] = cred_q[k];
      if (lce_req_ready_o[k] && !credit_return_i[k]) begin
        cred_d[k] = cred_q[k] + 1'b1;
      end else if (!lce_req_ready_o[k] && credit_return_i[k]) begin
        if (cred_q[k] == '0) uflow = 1'b1;
        else cred_d[k] = cred_q[k] - 1'b1;
      end
    end
  end

  always_comb begin
    cmd_dst = lce_cmd_i[cmd_dst_lsb_p +: IW];
    cmd_tgt = '0;
    cmd_hit = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!cmd_hit && lce_id_i[k*IW +: IW] == cmd_dst) begin
        cmd_tgt[k] = 1'b1;
        cmd_hit    = 1'b1;
      end
    end
    lce_cmd_yumi_o = ~reset_i & lce_cmd_v_i
                   & (~cmd_hit | |(cmd_tgt & (~cmd_full_q | lce_cmd_yumi_i)));
    cmd_miss = lce_cmd_yumi_o & ~cmd_hit;
    cmd_data_d = cmd_data_q;
    for (int k = 0; k < N; k++) begin
      cmd_full_d[k] = cmd_full_q[k] & ~lce_cmd_yumi_i[k];
      if (cmd_tgt[k] && lce_cmd_yumi_o) begin
        cmd_full_d[k]              = 1'b1;
        cmd_data_d[k*CMW +: CMW]   = lce_cmd_i;
      end
    end
    error_d = error_q | uflow | cmd_miss;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      req_full_q  <= 1'b0;
      req_data_q  <= '0;
      req_ptr_q   <= '0;
      resp_full_q <= 1'b0;
      resp_data_q <= '0;
      resp_ptr_q  <= '0;
      cmd_full_q  <= '0;
      cmd_data_q  <= '0;
      error_q     <= 1'b0;
      for (int k = 0; k < N; k++) cred_q[k] <= '0;
    end else begin
      req_full_q  <= req_full_d;
      req_data_q  <= req_data_d;
      req_ptr_q   <= req_ptr_d;
      resp_full_q <= resp_full_d;
      resp_data_q <= resp_data_d;
      resp_ptr_q  <= resp_ptr_d;
      cmd_full_q  <= cmd_full_d;
      cmd_data_q  <= cmd_data_d;
      error_q     <= error_d;
      for (int k = 0; k < N; k++) cred_q[k] <= cred_d[k];
    end
  end

  assign lce_req_o    = req_data_q;
  assign lce_req_v_o  = req_full_q;
  assign lce_resp_o   = resp_data_q;
  assign lce_resp_v_o = resp_full_q;
  assign lce_cmd_o    = cmd_data_q;
  assign lce_cmd_v_o  = cmd_full_q;
  assign error_o      = error_q;

`ifdef BP_COH_MUX_STATS_EN
  logic [31:0] stat_q [N];
  logic [31:0] stat_d [N];

  always_comb begin
    for (int k = 0; k < N; k++) begin
      stat_d[k] = stat_q[k];
      if (lce_req_ready_o[k] && stat_q[k] != 32'hFFFF_FFFF) begin
        stat_d[k] = stat_q[k] + 32'd1;
      end
      stat_grants_o[k*32 +: 32] = stat_q[k];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int k = 0; k < N; k++) stat_q[k] <= '0;
    end else begin
      for (int k = 0; k < N; k++) stat_q[k] <= stat_d[k];
    end
  end
`else
  assign stat_grants_o = '0;
`endif

endmodule
